// File: rtl/wbm_spi_tx_if.sv
// Byte handshake between the Wishbone-side logic and the SPI transmit path.
// The master supplies bytes; the slave (wbm_spi_tx) reports loads and underruns.
interface wbm_spi_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_load;
  logic       underrun;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_load,
    input  underrun
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_load,
    output underrun
  );
endinterface

// File: rtl/wbm_spi_tx.sv
// SPI mode-0 slave transmitter, MSB first, oversampled in the clk domain.
// A one-byte holding register feeds the shift register; IDLE_BYTE fills underruns.
module wbm_spi_tx #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spi_sck,
  input  logic         spi_csn,
  output logic         spi_sdo,
  wbm_spi_tx_if.slave  tx
);

  // [0],[1] form the synchronizer, [2] is the previous synchronized value
  logic [2:0] sck_q;
  logic [2:0] csn_q;

  logic       sel_start_d, sel_end_d, sck_fall_d;
  logic       sel_start_q, sel_end_q, sck_fall_q;

  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       tx_load_q, tx_load_d;
  logic       underrun_q, underrun_d;

  logic       load;
  logic       accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q       <= 3'b000;
      csn_q       <= 3'b111;
      sel_start_q <= 1'b0;
      sel_end_q   <= 1'b0;
      sck_fall_q  <= 1'b0;
    end else begin
      sck_q       <= {sck_q[1:0], spi_sck};
      csn_q       <= {csn_q[1:0], spi_csn};
      sel_start_q <= sel_start_d;
      sel_end_q   <= sel_end_d;
      sck_fall_q  <= sck_fall_d;
    end
  end

  assign sel_start_d = csn_q[2] & ~csn_q[1];
  assign sel_end_d   = ~csn_q[2] & csn_q[1];
  assign sck_fall_d  = sck_q[2] & ~sck_q[1] & ~csn_q[1];

  assign load   = sel_start_q | (sck_fall_q & (cnt_q == 3'd7));
  assign accept = tx.tx_valid & ~hold_full_q;

  // NOTE: every signal driven here gets its default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    tx_load_d   = 1'b0;
    underrun_d  = 1'b0;

    if (load) begin
      cnt_d = 3'd0;
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
        tx_load_d   = 1'b1;
      end else begin
        shift_d    = IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end else if (sck_fall_q) begin
      shift_d = {shift_q[6:0], 1'b0};
      cnt_d   = cnt_q + 3'd1;
    end else if (sel_end_q) begin
      cnt_d = 3'd0;
    end

    // A load only consumes a full hold and an accept only fills an empty one,
    // so both can be applied in the same cycle without interfering.
    if (accept) begin
      hold_d      = tx.tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      shift_q     <= IDLE_BYTE;
      cnt_q       <= 3'd0;
      tx_load_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tx_load_q   <= tx_load_d;
      underrun_q  <= underrun_d;
    end
  end

  // NOTE: the holding data needs no reset; hold_full qualifies it and is reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign spi_sdo     = shift_q[7];
  assign tx.tx_ready = ~hold_full_q;
  assign tx.tx_load  = tx_load_q;
  assign tx.underrun = underrun_q;

endmodule

// File: tb/tb_wbm_spi_tx.sv
// Directed and randomized bench for wbm_spi_tx acting as an SPI mode-0 controller.
// The reference model tracks the pending byte queue and byte boundaries only.
module tb_wbm_spi_tx;

  localparam logic [7:0] IDLE = 8'hFF;

  logic clk = 1'b0;
  logic rst;
  logic spi_sck;
  logic spi_csn;
  logic sdo;
  logic sdo_z;

  wbm_spi_tx_if bus ();
  wbm_spi_tx_if bus_z ();

  wbm_spi_tx #(.IDLE_BYTE(IDLE)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .spi_sck (spi_sck),
    .spi_csn (spi_csn),
    .spi_sdo (sdo),
    .tx      (bus)
  );

  // Second instance with the default idle byte; it never receives data.
  wbm_spi_tx #(.IDLE_BYTE(8'h00)) u_dut_z (
    .clk     (clk),
    .rst     (rst),
    .spi_sck (spi_sck),
    .spi_csn (spi_csn),
    .spi_sdo (sdo_z),
    .tx      (bus_z)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model state
  logic [7:0] pend[$];
  logic [7:0] exp_cur;
  logic [7:0] rx;
  logic [7:0] rx_z;
  int         nrx;
  int         m_load  = 0;
  int         m_under = 0;

  // Observed pulse counts
  int n_load  = 0;
  int n_under = 0;
  int n_both  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_load === 1'b1)  n_load++;
      if (bus.underrun === 1'b1) n_under++;
      if (bus.tx_load === 1'b1 && bus.underrun === 1'b1) n_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A byte boundary: the pending byte if any, otherwise the idle byte.
  task automatic model_load();
    if (pend.size() != 0) begin
      exp_cur = pend.pop_front();
      m_load++;
    end else begin
      exp_cur = IDLE;
      m_under++;
    end
    rx   = 8'h00;
    rx_z = 8'h00;
    nrx  = 0;
  endtask

  task automatic push(input logic [7:0] b);
    check("ready_before_push", bus.tx_ready, 1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    pend.push_back(b);
    @(negedge clk);
    check("ready_after_push", bus.tx_ready, 0);
  endtask

  task automatic select(input int half);
    spi_csn = 1'b0;
    model_load();
    wait_clk(half);
  endtask

  // Controller samples on the rising edge; the DUT shifts on the falling edge.
  task automatic clock_bit(input int half);
    rx   = {rx[6:0], sdo};
    rx_z = {rx_z[6:0], sdo_z};
    nrx++;
    spi_sck = 1'b1;
    wait_clk(half);
    spi_sck = 1'b0;
    if (nrx == 8) begin
      check("byte", rx, exp_cur);
      check("byte_idle00", rx_z, 8'h00);
      model_load();
    end
    wait_clk(half);
  endtask

  task automatic deselect();
    logic [7:0] exp_part;
    if (nrx != 0) begin
      exp_part = exp_cur >> (8 - nrx);
      check("partial", rx, exp_part);
    end
    spi_csn = 1'b1;
    nrx = 0;
    wait_clk(8);
  endtask

  task automatic check_pulses();
    wait_clk(6);
    check("load_count", n_load, m_load);
    check("underrun_count", n_under, m_under);
  endtask

  initial begin
    int half;
    int nb;
    int ab_bit;
    bit abort;
    bit stop;

    rst           = 1'b1;
    spi_sck       = 1'b0;
    spi_csn       = 1'b1;
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;
    bus_z.tx_data = 8'h00;
    bus_z.tx_valid = 1'b0;

    phase = "reset";
    wait_clk(4);
    check("tx_ready", bus.tx_ready, 1);
    check("sdo", sdo, IDLE[7]);
    check("sdo_idle00", sdo_z, 0);
    check("tx_load", bus.tx_load, 0);
    check("underrun", bus.underrun, 0);
    rst = 1'b0;
    wait_clk(4);
    check("sdo_idle_after_reset", sdo, IDLE[7]);

    phase = "single";
    push(8'hA5);
    select(8);
    for (int i = 0; i < 8; i++) clock_bit(8);
    check("tx_ready_restored", bus.tx_ready, 1);
    deselect();
    check_pulses();

    phase = "back2back";
    push(8'h3C);
    select(8);
    push(8'hC3);
    // Valid while the holding register is full must be ignored.
    bus.tx_data  = 8'hEE;
    bus.tx_valid = 1'b1;
    wait_clk(3);
    bus.tx_valid = 1'b0;
    wait_clk(2);
    for (int i = 0; i < 16; i++) clock_bit(8);
    deselect();
    check_pulses();

    phase = "underrun";
    select(8);
    for (int i = 0; i < 4; i++) clock_bit(8);
    push(8'h12);
    for (int i = 0; i < 12; i++) clock_bit(8);
    deselect();
    check_pulses();

    phase = "abort";
    push(8'h81);
    select(8);
    push(8'h7E);
    for (int i = 0; i < 3; i++) clock_bit(8);
    deselect();
    select(8);
    for (int i = 0; i < 8; i++) clock_bit(8);
    deselect();
    check_pulses();

    phase = "same_cycle";
    check("hold_empty", bus.tx_ready, 1);
    spi_csn = 1'b0;
    model_load();
    wait_clk(3);
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    wait_clk(1);
    bus.tx_valid = 1'b0;
    pend.push_back(8'h55);
    wait_clk(4);
    for (int i = 0; i < 16; i++) clock_bit(8);
    deselect();
    check_pulses();

    phase = "reset_mid";
    push(8'hAA);
    select(8);
    for (int i = 0; i < 2; i++) clock_bit(8);
    push(8'h99);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    pend.delete();
    check("tx_ready_after_reset", bus.tx_ready, 1);
    model_load();
    wait_clk(8);
    for (int i = 0; i < 8; i++) clock_bit(8);
    deselect();
    check_pulses();

    phase = "random";
    for (int t = 0; t < 14; t++) begin
      half   = $urandom_range(6, 10);
      nb     = $urandom_range(1, 3);
      abort  = ($urandom_range(0, 3) == 0);
      ab_bit = $urandom_range(1, 7);
      stop   = 1'b0;
      select(half);
      for (int b = 0; b < nb && !stop; b++) begin
        for (int i = 0; i < 8 && !stop; i++) begin
          if (abort && b == nb - 1 && i == ab_bit) begin
            stop = 1'b1;
          end else begin
            clock_bit(half);
            if (i == 3 && pend.size() == 0 && $urandom_range(0, 2) != 0)
              push(8'($urandom_range(0, 255)));
          end
        end
      end
      deselect();
      // Clock edges while deselected must have no effect.
      for (int k = 0; k < 2; k++) begin
        spi_sck = 1'b1;
        wait_clk(half);
        spi_sck = 1'b0;
        wait_clk(half);
      end
      check_pulses();
    end

    phase = "final";
    check("exclusive_pulses", n_both, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
